cy_slave_fifo_responder: RTL and testbench
==========================================

// Module: cy_slave_fifo_responder
// PURPOSE
//  FX2 (CY7C68013) slave-FIFO device-side responder: the end that answers the FPGA master's
//  SLRD/SLWR/SLOE/FIFOADR/PKTEND strobes.
//  Holds an OUT endpoint (EP2, host->master) and an IN endpoint (EP6, master->host) with FX2 flags.
//  Host-side valid/ready ports stand in for USB traffic.
//  Used as loopback / bench partner for the cy68013 master path and for FPGA-to-FPGA links.
// PARAMETERS
//  DEPTH_LOG2  9    log2 bytes per endpoint FIFO (512 B)
//  PKT_SIZE    512  EP6 auto-commit packet length in bytes (<= 2**DEPTH_LOG2)
//  PKT_Q_LOG2  2    log2 entries in EP6 committed-packet length queue
// PORTS
//  sys_clk        in   1   sole clock; all strobes sampled here
//  sys_rst        in   1   synchronous reset, active-high
//  slrd_n         in   1   read strobe, active-low
//  slwr_n         in   1   write strobe, active-low
//  sloe_n         in   1   output enable, active-low
//  fifoadr        in   2   endpoint select: 2'b00=EP2, 2'b10=EP6, others=none
//  pktend_n       in   1   commit short/zero-length IN packet, active-low
//  fd_in          in   8   data from master
//  fd_out         out  8   data to master (EP2 head byte)
//  fd_oe          out  1   drive enable for the FD bus
//  flaga_n        out  1   EP2 empty, low when empty
//  flagb_n        out  1   EP6 full, low when full
//  flagc_n        out  1   EP6 empty, low when empty
//  flagd_n        out  1   EP2 full, low when full
//  host_wr_valid  in   1   host byte into EP2
//  host_wr_data   in   8   host byte
//  host_wr_ready  out  1   EP2 not full
//  host_rd_valid  out  1   committed EP6 byte available
//  host_rd_data   out  8   EP6 byte
//  host_rd_last   out  1   last byte of the current committed packet
//  host_rd_ready  in   1   host accepts byte
//  zlp_pulse      out  1   1-cycle pulse: zero-length packet committed
//  err_underflow  out  1   sticky: SLRD on empty EP2
//  err_overflow   out  1   sticky: SLWR on full EP6
// BEHAVIOUR
//  Reset (sync, active-high):
//   - both FIFOs, counters and length queue emptied; fd_out=0, fd_oe=0
//   - flaga_n=0, flagc_n=0, flagb_n=1, flagd_n=1; host_rd_valid=0; zlp_pulse=0; err_*=0
//   - host_wr_ready=1 from the first cycle after reset
//   - reset mid-transfer discards all data, including partially accumulated packets
//  Strobes: each registered once (prev copy kept); an action fires on a 1->0 edge only.
//   - a held-low strobe is one action
//   - fifoadr is sampled in the same cycle as the edge
//  EP2 read: SLRD edge with fifoadr=00 and EP2 non-empty pops one byte.
//   - fd_out shows the new head 1 cycle later
//   - fd_out = head byte whenever EP2 is non-empty, else holds the last value
//   - edge on empty EP2: no pop, err_underflow<=1
//  fd_oe: registered (!sloe_n && fifoadr==00); 1-cycle latency.
//  EP6 write: SLWR edge with fifoadr=10 pushes fd_in into EP6.
//   - when full: byte dropped, err_overflow<=1
//   - uncommitted count ucnt increments on every push
//  EP6 commit:
//   - auto-commit when ucnt reaches PKT_SIZE: length pushed to queue, ucnt<=0
//   - PKTEND edge with fifoadr=10 commits ucnt bytes; if ucnt==0, zlp_pulse=1 and no queue entry
//   - SLWR and PKTEND edges in the same cycle: byte pushed first, commit includes it
//   - length queue full: commit held pending and PKTEND ignored until a slot frees
//  Host read:
//   - host_rd_valid=1 when queue non-empty; byte transferred when valid && ready
//   - host_rd_last=1 when the remaining count of the head packet == 1
//   - uncommitted bytes are never visible to host
//  Host write: push when valid && ready.
//  Simultaneous push+pop on one FIFO: count unchanged.
//  Flags: registered, valid 1 cycle after the causing push/pop. Pointers wrap modulo 2**DEPTH_LOG2.
//  Full = count == 2**DEPTH_LOG2 (count is DEPTH_LOG2+1 bits).
// CONFIGURATION
//  CY_STROBE_SYNC_EN defined:
//   - slrd_n/slwr_n/sloe_n/pktend_n/fifoadr pass 2-flop synchronizers before edge detect
//   - action latency 3 cycles from pin edge; use for asynchronous masters
//  Undefined: single register, action latency 1 cycle. Flag timing relative to action is unchanged.
// TESTING
//  1 host writes 0x11,0x22,0x33; master SLRD x3 at fifoadr=00 -> fd_out 11,22,33; flaga_n=0 after 3rd.
//  2 master SLWR x512 at fifoadr=10 -> auto-commit; host reads 512 B, host_rd_last on 512th only.
//  3 SLWR x5 then PKTEND -> host gets 5 B, last on 5th; PKTEND with ucnt=0 -> zlp_pulse one cycle.
//  4 SLRD on empty EP2 -> err_underflow=1; 513th SLWR with EP6 full -> byte dropped, err_overflow=1.
//  5 SLWR and PKTEND same cycle after 2 bytes -> committed packet length 3.
//  6 reset asserted mid-packet (ucnt=7) -> all flags at reset values next cycle, host_rd_valid=0.

Source files
------------

// File: rtl/cy_slave_fifo_responder.sv
// cy_slave_fifo_responder: FX2 slave-FIFO device-side responder (EP2 OUT, EP6 IN); define CY_STROBE_SYNC_EN to add 2-flop strobe synchronizers
module cy_slave_fifo_responder #(
    parameter int DEPTH_LOG2 = 9,
    parameter int PKT_SIZE   = 512,
    parameter int PKT_Q_LOG2 = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       slrd_n,
    input  logic       slwr_n,
    input  logic       sloe_n,
    input  logic [1:0] fifoadr,
    input  logic       pktend_n,
    input  logic [7:0] fd_in,
    output logic [7:0] fd_out,
    output logic       fd_oe,
    output logic       flaga_n,
    output logic       flagb_n,
    output logic       flagc_n,
    output logic       flagd_n,
    input  logic       host_wr_valid,
    input  logic [7:0] host_wr_data,
    output logic       host_wr_ready,
    output logic       host_rd_valid,
    output logic [7:0] host_rd_data,
    output logic       host_rd_last,
    input  logic       host_rd_ready,
    output logic       zlp_pulse,
    output logic       err_underflow,
    output logic       err_overflow
);
    localparam int W  = DEPTH_LOG2 + 1;
    localparam int QW = PKT_Q_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PKT   = W'(PKT_SIZE);
    localparam logic [PKT_Q_LOG2:0] QFULL = {1'b1, {PKT_Q_LOG2{1'b0}}};

    logic [5:0] pins, strb;
    assign pins = {slrd_n, slwr_n, sloe_n, pktend_n, fifoadr};
`ifdef CY_STROBE_SYNC_EN
    logic [5:0] sync1;
    // two-flop synchronizer so asynchronous masters can drive the strobes
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1 <= 6'b111100;
            strb  <= 6'b111100;
        end else begin
            sync1 <= pins;
            strb  <= sync1;
        end
    end
`else
    assign strb = pins;
`endif

    logic       slrd_s, slwr_s, sloe_s, pktend_s;
    logic [1:0] adr_s;
    logic       slrd_p, slwr_p, pktend_p;
    logic       rd_edge, wr_edge, pe_edge;
    assign {slrd_s, slwr_s, sloe_s, pktend_s, adr_s} = strb;

    // previous strobe levels; a held-low strobe yields a single falling edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            slrd_p   <= 1'b1;
            slwr_p   <= 1'b1;
            pktend_p <= 1'b1;
        end else begin
            slrd_p   <= slrd_s;
            slwr_p   <= slwr_s;
            pktend_p <= pktend_s;
        end
    end

    assign rd_edge = slrd_p & ~slrd_s & (adr_s == 2'b00);
    assign wr_edge = slwr_p & ~slwr_s & (adr_s == 2'b10);
    assign pe_edge = pktend_p & ~pktend_s & (adr_s == 2'b10);

    logic [7:0]            mem2 [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp2, rp2, rp2_n;
    logic [DEPTH_LOG2:0]   cnt2, cnt2_n;
    logic                  push2, pop2;
    logic [7:0]            head2;

    assign host_wr_ready = flagd_n;
    assign push2  = host_wr_valid & host_wr_ready;
    assign pop2   = rd_edge & (cnt2 != '0);
    assign rp2_n  = rp2 + DEPTH_LOG2'(pop2);
    assign cnt2_n = cnt2 + W'(push2) - W'(pop2);
    assign head2  = (push2 && rp2_n == wp2) ? host_wr_data : mem2[rp2_n];

    logic [7:0]            mem6 [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp6, rp6;
    logic [DEPTH_LOG2:0]   cnt6, cnt6_n, ucnt, ucnt_inc, rd_off, pend_len, lq_data;
    logic [DEPTH_LOG2:0]   lq [2**PKT_Q_LOG2];
    logic [PKT_Q_LOG2-1:0] lwp, lrp;
    logic [PKT_Q_LOG2:0]   lcnt;
    logic                  push6, pop6, pend, commit, lq_slot, lq_push, lq_pop;

    assign push6         = wr_edge & (cnt6 != FULL);
    assign host_rd_valid = lcnt != '0;
    assign host_rd_data  = mem6[rp6];
    assign host_rd_last  = host_rd_valid & (lq[lrp] == rd_off + W'(1));
    assign pop6          = host_rd_valid & host_rd_ready;
    assign lq_pop        = pop6 & host_rd_last;
    assign ucnt_inc      = ucnt + W'(push6);
    assign commit        = ~pend & ((ucnt_inc == PKT) | (pe_edge & (ucnt_inc != '0)));
    assign lq_slot       = (lcnt != QFULL) | lq_pop;
    assign lq_push       = (pend | commit) & lq_slot;
    assign lq_data       = pend ? pend_len : ucnt_inc;
    assign cnt6_n        = cnt6 + W'(push6) - W'(pop6);

    // byte and packet-length storage, contents need no reset
    always_ff @(posedge sys_clk) begin
        if (push2) mem2[wp2] <= host_wr_data;
        if (push6) mem6[wp6] <= fd_in;
        if (lq_push) lq[lwp] <= lq_data;
    end

    // EP2: host pushes, master pops; fd_out tracks the head byte
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wp2           <= '0;
            rp2           <= '0;
            cnt2          <= '0;
            fd_out        <= '0;
            fd_oe         <= 1'b0;
            flaga_n       <= 1'b0;
            flagd_n       <= 1'b1;
            err_underflow <= 1'b0;
        end else begin
            wp2           <= wp2 + DEPTH_LOG2'(push2);
            rp2           <= rp2_n;
            cnt2          <= cnt2_n;
            fd_out        <= (cnt2_n != '0) ? head2 : fd_out;
            fd_oe         <= ~sloe_s & (adr_s == 2'b00);
            flaga_n       <= cnt2_n != '0;
            flagd_n       <= cnt2_n != FULL;
            err_underflow <= err_underflow | (rd_edge & (cnt2 == '0));
        end
    end

    // EP6: master pushes, commits whole packets into the length queue, host drains committed bytes
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wp6          <= '0;
            rp6          <= '0;
            cnt6         <= '0;
            ucnt         <= '0;
            rd_off       <= '0;
            pend         <= 1'b0;
            pend_len     <= '0;
            lwp          <= '0;
            lrp          <= '0;
            lcnt         <= '0;
            flagb_n      <= 1'b1;
            flagc_n      <= 1'b0;
            zlp_pulse    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            wp6          <= wp6 + DEPTH_LOG2'(push6);
            rp6          <= rp6 + DEPTH_LOG2'(pop6);
            cnt6         <= cnt6_n;
            ucnt         <= commit ? '0 : ucnt_inc;
            rd_off       <= lq_pop ? '0 : rd_off + W'(pop6);
            pend         <= pend ? ~lq_slot : (commit & ~lq_slot);
            pend_len     <= (commit & ~lq_slot) ? ucnt_inc : pend_len;
            lwp          <= lwp + PKT_Q_LOG2'(lq_push);
            lrp          <= lrp + PKT_Q_LOG2'(lq_pop);
            lcnt         <= lcnt + QW'(lq_push) - QW'(lq_pop);
            flagb_n      <= cnt6_n != FULL;
            flagc_n      <= cnt6_n != '0;
            zlp_pulse    <= ~pend & pe_edge & (ucnt_inc == '0);
            err_overflow <= err_overflow | (wr_edge & (cnt6 == FULL));
        end
    end
endmodule

// File: tb/tb_cy_slave_fifo_responder.sv
// tb_cy_slave_fifo_responder: queue-model and directed checks for the slave-FIFO responder
module tb_cy_slave_fifo_responder;
    logic       sys_clk, sys_rst;
    logic       slrd_n, slwr_n, sloe_n, pktend_n;
    logic [1:0] fifoadr;
    logic [7:0] fd_in, fd_out;
    logic       fd_oe, flaga_n, flagb_n, flagc_n, flagd_n;
    logic       host_wr_valid, host_wr_ready;
    logic [7:0] host_wr_data, host_rd_data;
    logic       host_rd_valid, host_rd_last, host_rd_ready;
    logic       zlp_pulse, err_underflow, err_overflow;

    cy_slave_fifo_responder dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .slrd_n(slrd_n), .slwr_n(slwr_n), .sloe_n(sloe_n), .fifoadr(fifoadr), .pktend_n(pktend_n),
        .fd_in(fd_in), .fd_out(fd_out), .fd_oe(fd_oe),
        .flaga_n(flaga_n), .flagb_n(flagb_n), .flagc_n(flagc_n), .flagd_n(flagd_n),
        .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
        .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data), .host_rd_last(host_rd_last),
        .host_rd_ready(host_rd_ready), .zlp_pulse(zlp_pulse),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        sys_clk = 0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // reference model: byte queues per endpoint, a list of committed packet lengths
    byte unsigned q2[$];
    byte unsigned q6[$];
    int           lens[$];
    int           m_ucnt, m_off, m_plen;
    bit           m_pend, m_on, p_rd, p_wr, p_pe;
    logic [7:0]   e_fd;
    bit           e_oe, e_zlp, e_unf, e_ovf;
    bit           rd_e, wr_e, pe_e, full6, hw, hr, hlast, pend0;

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            q2.delete();
            q6.delete();
            lens.delete();
            m_ucnt = 0;
            m_off = 0;
            m_plen = 0;
            m_pend = 0;
            p_rd = 1;
            p_wr = 1;
            p_pe = 1;
            e_fd = 0;
            e_oe = 0;
            e_zlp = 0;
            e_unf = 0;
            e_ovf = 0;
            m_on = 1;
        end else begin
            rd_e = p_rd && !slrd_n && fifoadr == 2'b00;
            wr_e = p_wr && !slwr_n && fifoadr == 2'b10;
            pe_e = p_pe && !pktend_n && fifoadr == 2'b10;
            p_rd = slrd_n;
            p_wr = slwr_n;
            p_pe = pktend_n;
            full6 = q6.size() == 512;
            hw = host_wr_valid && q2.size() < 512;
            hr = host_rd_ready && lens.size() > 0;
            hlast = hr && (lens[0] - m_off == 1);
            pend0 = m_pend;
            if (rd_e) begin
                if (q2.size() > 0) void'(q2.pop_front());
                else e_unf = 1;
            end
            if (hw) q2.push_back(host_wr_data);
            if (hr) begin
                void'(q6.pop_front());
                if (hlast) begin
                    void'(lens.pop_front());
                    m_off = 0;
                end else m_off++;
            end
            if (wr_e) begin
                if (full6) e_ovf = 1;
                else begin
                    q6.push_back(fd_in);
                    m_ucnt++;
                end
            end
            e_zlp = !pend0 && pe_e && m_ucnt == 0;
            if (pend0) begin
                if (lens.size() < 4) begin
                    lens.push_back(m_plen);
                    m_pend = 0;
                end
            end else if (m_ucnt == 512 || (pe_e && m_ucnt > 0)) begin
                if (lens.size() < 4) lens.push_back(m_ucnt);
                else begin
                    m_pend = 1;
                    m_plen = m_ucnt;
                end
                m_ucnt = 0;
            end
            if (q2.size() > 0) e_fd = q2[0];
            e_oe = !sloe_n && fifoadr == 2'b00;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge sys_clk) begin
        if (m_on) begin
            chk("fd_out", fd_out, e_fd);
            chk("fd_oe", fd_oe, e_oe);
            chk("flaga_n", flaga_n, q2.size() != 0);
            chk("flagd_n", flagd_n, q2.size() != 512);
            chk("host_wr_ready", host_wr_ready, q2.size() != 512);
            chk("flagb_n", flagb_n, q6.size() != 512);
            chk("flagc_n", flagc_n, q6.size() != 0);
            chk("host_rd_valid", host_rd_valid, lens.size() != 0);
            if (lens.size() != 0) begin
                chk("host_rd_data", host_rd_data, q6[0]);
                chk("host_rd_last", host_rd_last, lens[0] - m_off == 1);
            end
            chk("zlp_pulse", zlp_pulse, e_zlp);
            chk("err_underflow", err_underflow, e_unf);
            chk("err_overflow", err_overflow, e_ovf);
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_rd();
        fifoadr = 2'b00;
        slrd_n = 0;
        step();
        slrd_n = 1;
        step();
    endtask

    task automatic do_wr(input logic [7:0] b);
        fifoadr = 2'b10;
        fd_in = b;
        slwr_n = 0;
        step();
        slwr_n = 1;
        step();
    endtask

    task automatic do_pktend();
        fifoadr = 2'b10;
        pktend_n = 0;
        step();
        pktend_n = 1;
        step();
    endtask

    task automatic host_read(output int n, output int last_at);
        n = 0;
        last_at = -1;
        host_rd_ready = 1;
        for (int c = 0; c < 1000 && last_at < 0; c++) begin
            @(negedge sys_clk);
            if (host_rd_valid) begin
                n++;
                if (host_rd_last) last_at = n;
            end
            step();
        end
        host_rd_ready = 0;
    endtask

    logic [7:0] t1 [3];
    int n, la;

    initial begin
        t1 = '{8'h11, 8'h22, 8'h33};
        sys_rst = 1;
        slrd_n = 1;
        slwr_n = 1;
        sloe_n = 1;
        pktend_n = 1;
        fifoadr = 2'b00;
        fd_in = 0;
        host_wr_valid = 0;
        host_wr_data = 0;
        host_rd_ready = 0;
        repeat (3) step();
        sys_rst = 0;
        step();
        chk("rst_flaga_n", flaga_n, 0);
        chk("rst_flagb_n", flagb_n, 1);
        chk("rst_flagc_n", flagc_n, 0);
        chk("rst_flagd_n", flagd_n, 1);
        chk("rst_wr_ready", host_wr_ready, 1);
        chk("rst_rd_valid", host_rd_valid, 0);

        for (int i = 0; i < 3; i++) begin
            host_wr_valid = 1;
            host_wr_data = t1[i];
            step();
        end
        host_wr_valid = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t1_fd_out", fd_out, t1[i]);
            do_rd();
        end
        chk("t1_fd_hold", fd_out, 8'h33);
        chk("t1_flaga_n", flaga_n, 0);
        sloe_n = 0;
        step();
        chk("oe_on", fd_oe, 1);
        sloe_n = 1;
        step();
        chk("oe_off", fd_oe, 0);

        do_rd();
        chk("t4_underflow", err_underflow, 1);

        for (int i = 0; i < 512; i++) do_wr(8'(i));
        chk("t2_flagb_full", flagb_n, 0);
        chk("t2_rd_valid", host_rd_valid, 1);
        chk("t2_no_ovf", err_overflow, 0);
        do_wr(8'hEE);
        chk("t4_overflow", err_overflow, 1);
        host_read(n, la);
        chk("t2_count", n, 512);
        chk("t2_last_at", la, 512);
        chk("t2_flagc_empty", flagc_n, 0);

        for (int i = 0; i < 5; i++) do_wr(8'hA0 + 8'(i));
        chk("t3_uncommitted_hidden", host_rd_valid, 0);
        do_pktend();
        host_read(n, la);
        chk("t3_count", n, 5);
        chk("t3_last_at", la, 5);
        fifoadr = 2'b10;
        pktend_n = 0;
        step();
        chk("t3_zlp_on", zlp_pulse, 1);
        pktend_n = 1;
        step();
        chk("t3_zlp_off", zlp_pulse, 0);

        do_wr(8'h51);
        do_wr(8'h52);
        fifoadr = 2'b10;
        fd_in = 8'h53;
        slwr_n = 0;
        pktend_n = 0;
        step();
        slwr_n = 1;
        pktend_n = 1;
        step();
        host_read(n, la);
        chk("t5_count", n, 3);
        chk("t5_last_at", la, 3);

        for (int k = 0; k < 5; k++) begin
            do_wr(8'hC0 + 8'(k));
            do_pktend();
        end
        fifoadr = 2'b10;
        pktend_n = 0;
        step();
        chk("pend_zlp_ignored", zlp_pulse, 0);
        pktend_n = 1;
        step();
        for (int k = 0; k < 5; k++) begin
            host_read(n, la);
            chk("pend_count", n, 1);
            chk("pend_last_at", la, 1);
        end
        chk("pend_drained", host_rd_valid, 0);

        host_wr_valid = 1;
        host_wr_data = 8'h77;
        step();
        host_wr_valid = 0;
        for (int i = 0; i < 7; i++) do_wr(8'(i));
        sys_rst = 1;
        step();
        chk("t6_flaga_n", flaga_n, 0);
        chk("t6_flagb_n", flagb_n, 1);
        chk("t6_flagc_n", flagc_n, 0);
        chk("t6_flagd_n", flagd_n, 1);
        chk("t6_rd_valid", host_rd_valid, 0);
        chk("t6_fd_out", fd_out, 0);
        chk("t6_err_unf", err_underflow, 0);
        chk("t6_err_ovf", err_overflow, 0);
        sys_rst = 0;
        step();
        chk("t6_wr_ready", host_wr_ready, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
